// File: rtl/pov_control.sv
// rtl/pov_control.sv - POV display sequencer: sync-triggered string load, per-character column timing.
module pov_control #(
   parameter int COL_CYCLES    = 1000,
   parameter int COLS_PER_CHAR = 5,
   parameter int MAX_CHARS     = 7
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       enable_i,
   input  logic       index_sync_i,
   input  logic       null_string_i,
   input  logic       null_data_char_i,
   output logic       load_string_o,
   output logic       compare_string_o,
   output logic       load_char_o,
   output logic       shift_string_o,
   output logic [2:0] column_o,
   output logic       led_enable_o,
   output logic       busy_o,
   output logic       empty_string_o,
   output logic       overrun_o
);

   localparam int TW = (COL_CYCLES > 1) ? $clog2(COL_CYCLES) : 1;
   localparam int CW = $clog2(MAX_CHARS + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(COL_CYCLES - 1);
   localparam logic [CW-1:0] COUNT_LAST = CW'(MAX_CHARS);
   localparam logic [2:0]    GAP_COL    = 3'(COLS_PER_CHAR);

   typedef enum logic [3:0] {
      IDLE, WAIT_SYNC, LOAD, CHECK, CHK_WAIT, FETCH, FETCH_WAIT, COLUMN, NEXT
   } state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [CW-1:0] count_q, count_d;
   logic [2:0]    column_q, column_d;
   logic          empty_q, empty_d;
   logic          load_string_q, compare_string_q, load_char_q, shift_string_q;
   logic          led_q, busy_q;
   logic          overrun;

   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      count_d  = count_q;
      column_d = column_q;
      empty_d  = empty_q;
      overrun  = index_sync_i && !rst_i &&
                 (state_q inside {CHECK, CHK_WAIT, FETCH, FETCH_WAIT, COLUMN, NEXT});
      case (state_q)
         IDLE:      if (enable_i) state_d = WAIT_SYNC;
         WAIT_SYNC: begin
            // a sync arriving while the display is being switched off is dropped
            if (!enable_i)         state_d = IDLE;
            else if (index_sync_i) state_d = LOAD;
         end
         LOAD:      state_d = CHECK;
         CHECK:     state_d = CHK_WAIT;
         CHK_WAIT: begin
            if (null_string_i) begin
               empty_d = 1'b1;
               state_d = WAIT_SYNC;
            end else begin
               state_d = FETCH;
            end
         end
         FETCH:     state_d = FETCH_WAIT;
         FETCH_WAIT: begin
            if (null_data_char_i) begin
               state_d = WAIT_SYNC;
            end else begin
               column_d = '0;
               timer_d  = '0;
               state_d  = COLUMN;
            end
         end
         COLUMN: begin
            if (timer_q == TIMER_LAST) begin
               timer_d = '0;
               if (column_q < GAP_COL) column_d = column_q + 3'd1;
               else                    state_d  = NEXT;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         NEXT: begin
            count_d = count_q + 1'b1;
            if (!enable_i)                 state_d = IDLE;
            else if (count_d == COUNT_LAST) state_d = WAIT_SYNC;
            else                           state_d = FETCH;
         end
         default:   state_d = IDLE;
      endcase
      if (overrun) state_d = LOAD;
      // every entry into LOAD restarts the string, whether from a sync or an overrun
      if (state_d == LOAD) begin
         count_d  = '0;
         timer_d  = '0;
         column_d = '0;
         empty_d  = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q          <= IDLE;
         timer_q          <= '0;
         count_q          <= '0;
         column_q         <= '0;
         empty_q          <= 1'b0;
         load_string_q    <= 1'b0;
         compare_string_q <= 1'b0;
         load_char_q      <= 1'b0;
         shift_string_q   <= 1'b0;
         led_q            <= 1'b0;
         busy_q           <= 1'b0;
      end else begin
         state_q          <= state_d;
         timer_q          <= timer_d;
         count_q          <= count_d;
         column_q         <= column_d;
         empty_q          <= empty_d;
         load_string_q    <= (state_d == LOAD);
         compare_string_q <= (state_d == CHECK);
         load_char_q      <= (state_d == FETCH);
         shift_string_q   <= (state_d == NEXT);
         led_q            <= (state_d == COLUMN) && (column_d < GAP_COL);
         busy_q           <= (state_d != IDLE);
      end
   end

   assign load_string_o    = load_string_q;
   assign compare_string_o = compare_string_q;
   assign load_char_o      = load_char_q;
   assign shift_string_o   = shift_string_q;
   assign column_o         = column_q;
   assign led_enable_o     = led_q;
   assign busy_o           = busy_q;
   assign empty_string_o   = empty_q;
   assign overrun_o        = overrun;

endmodule

// File: tb/tb_pov_control.sv
// tb/tb_pov_control.sv - scoreboard bench for pov_control with COL_CYCLES=4, 5 columns, 7 chars.
module tb_pov_control;

   localparam int CHAR_PERIOD = 27;   // FETCH + FETCH_WAIT + 6 columns x 4 cycles + NEXT
   localparam int EV_LS = 1, EV_CS = 2, EV_LC = 3, EV_SH = 4, EV_OV = 5, EV_LED = 6;

   typedef struct {
      int code;
      int cyc;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b0;
   logic       index_sync = 1'b0;
   logic       null_string = 1'b0;
   logic       null_data_char = 1'b0;
   logic       load_string, compare_string, load_char, shift_string;
   logic [2:0] column;
   logic       led_enable, busy, empty_string, overrun;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   ev_t  exp_q[$];
   logic led_prev = 1'b0;

   pov_control #(.COL_CYCLES(4), .COLS_PER_CHAR(5), .MAX_CHARS(7)) dut (
      .clk_i(clk), .rst_i(rst), .enable_i(enable), .index_sync_i(index_sync),
      .null_string_i(null_string), .null_data_char_i(null_data_char),
      .load_string_o(load_string), .compare_string_o(compare_string),
      .load_char_o(load_char), .shift_string_o(shift_string), .column_o(column),
      .led_enable_o(led_enable), .busy_o(busy), .empty_string_o(empty_string),
      .overrun_o(overrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic string ev_name(input int code);
      case (code)
         EV_LS:   return "load_string";
         EV_CS:   return "compare_string";
         EV_LC:   return "load_char";
         EV_SH:   return "shift_string";
         EV_OV:   return "overrun";
         default: return "led_rise";
      endcase
   endfunction

   task automatic push(input int code, input int c);
      ev_t e;
      e.code = code;
      e.cyc  = c;
      exp_q.push_back(e);
   endtask

   task automatic push_hdr(input int base);
      push(EV_LS, base + 1);
      push(EV_CS, base + 2);
   endtask

   task automatic push_char(input int base, input int k);
      push(EV_LC,  base + 4  + CHAR_PERIOD * k);
      push(EV_LED, base + 6  + CHAR_PERIOD * k);
      push(EV_SH,  base + 30 + CHAR_PERIOD * k);
   endtask

   task automatic sb_pop(input int code);
      ev_t e;
      check({"sb_pending_", ev_name(code)}, int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check({"sb_kind_", ev_name(code)}, code, e.code);
         check({"sb_cycle_", ev_name(code)}, cyc, e.cyc);
      end
   endtask

   always @(negedge clk) begin
      if (load_string === 1'b1)    sb_pop(EV_LS);
      if (compare_string === 1'b1) sb_pop(EV_CS);
      if (load_char === 1'b1)      sb_pop(EV_LC);
      if (shift_string === 1'b1)   sb_pop(EV_SH);
      if (overrun === 1'b1)        sb_pop(EV_OV);
      if (led_enable === 1'b1 && led_prev !== 1'b1) sb_pop(EV_LED);
      led_prev <= led_enable;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_to(input int c);
      while (cyc < c) tick();
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_led"}, int'(led_enable), 0);
      check({tag, "_column"}, int'(column), 0);
      check({tag, "_empty"}, int'(empty_string), 0);
      check({tag, "_overrun"}, int'(overrun), 0);
      check({tag, "_strobes"},
            int'({load_string, compare_string, load_char, shift_string}), 0);
   endtask

   initial begin
      int n, a, m, p, q, r;
      repeat (3) tick();
      check_idle_outputs("reset");
      rst = 1'b0;
      tick();
      tick();
      check("idle_hold_busy", int'(busy), 0);

      // full seven-character string
      enable = 1'b1;
      tick();
      tick();
      check("wait_sync_busy", int'(busy), 1);
      n = cyc;
      index_sync = 1'b1;
      push_hdr(n);
      for (int k = 0; k < 7; k++) push_char(n, k);
      tick();
      index_sync = 1'b0;
      for (int j = 0; j < 6; j++) begin
         run_to(n + 8 + 4 * j);
         check($sformatf("col_index_%0d", j), int'(column), j);
         check($sformatf("col_led_%0d", j), int'(led_enable), int'(j < 5));
      end
      run_to(n + 196);
      check("full_end_busy", int'(busy), 1);
      check("full_end_led", int'(led_enable), 0);
      check("full_end_drained", exp_q.size(), 0);

      // empty string sets sticky flag, next load clears it
      null_string = 1'b1;
      a = cyc;
      index_sync = 1'b1;
      push_hdr(a);
      tick();
      index_sync = 1'b0;
      run_to(a + 4);
      check("empty_set", int'(empty_string), 1);
      check("empty_busy", int'(busy), 1);
      run_to(a + 8);
      check("empty_sticky", int'(empty_string), 1);
      null_string = 1'b0;

      // empty third character ends the string after two shifts
      m = cyc;
      index_sync = 1'b1;
      push_hdr(m);
      push_char(m, 0);
      push_char(m, 1);
      push(EV_LC, m + 58);
      tick();
      index_sync = 1'b0;
      check("empty_cleared", int'(empty_string), 0);
      run_to(m + 59);
      null_data_char = 1'b1;
      tick();
      null_data_char = 1'b0;
      run_to(m + 62);
      check("nullchar_busy", int'(busy), 1);
      check("nullchar_led", int'(led_enable), 0);
      check("nullchar_drained", exp_q.size(), 0);

      // overrun during the third character, then enable dropped mid-character
      p = cyc;
      q = p + 65;
      index_sync = 1'b1;
      push_hdr(p);
      push_char(p, 0);
      push_char(p, 1);
      push(EV_LC, p + 58);
      push(EV_LED, p + 60);
      push(EV_OV, q);
      push_hdr(q);
      push_char(q, 0);
      tick();
      index_sync = 1'b0;
      run_to(q);
      index_sync = 1'b1;
      tick();
      index_sync = 1'b0;
      check("overrun_reload_ls", int'(load_string), 1);
      check("overrun_column", int'(column), 0);
      check("overrun_led", int'(led_enable), 0);
      run_to(q + 15);
      enable = 1'b0;
      run_to(q + 29);
      check("disable_gap_busy", int'(busy), 1);
      run_to(q + 31);
      check("disable_idle_busy", int'(busy), 0);
      check("disable_idle_led", int'(led_enable), 0);
      check("disable_drained", exp_q.size(), 0);

      // sync coinciding with enable low in WAIT_SYNC goes idle
      enable = 1'b1;
      tick();
      tick();
      enable = 1'b0;
      index_sync = 1'b1;
      tick();
      index_sync = 1'b0;
      check("sync_vs_disable_busy", int'(busy), 0);
      repeat (4) tick();

      // reset in the middle of column 3 dominates sync and enable
      enable = 1'b1;
      tick();
      r = cyc;
      index_sync = 1'b1;
      push_hdr(r);
      push(EV_LC, r + 4);
      push(EV_LED, r + 6);
      tick();
      index_sync = 1'b0;
      run_to(r + 19);
      check("pre_reset_column", int'(column), 3);
      rst = 1'b1;
      index_sync = 1'b1;
      tick();
      index_sync = 1'b0;
      check_idle_outputs("midrun_reset");
      run_to(r + 22);
      rst = 1'b0;
      enable = 1'b0;
      run_to(r + 25);
      check("post_reset_busy", int'(busy), 0);
      check("final_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pov_control.md
POV_CONTROL -- requirements
Module: pov_control

Interface
REQ-001 Parameter COL_CYCLES, default 1000: clock cycles each display column is held.
REQ-002 Parameter COLS_PER_CHAR, default 5: lit columns per character; one blank gap column follows each character.
REQ-003 Parameter MAX_CHARS, default 7: characters per string.
REQ-004 Clock  input  1  single clock; all state changes on its rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 Enable  input  1  level; 1 = display running, 0 = return to IDLE at the next character boundary.
REQ-007 IndexSync  input  1  one-cycle pulse per rotation from the position sensor.
REQ-008 NullString  input  1  string-empty flag from the comparer, registered on CompareString rising edge.
REQ-009 NullDataChar  input  1  combinational current-character-empty flag from the comparer.
REQ-010 LoadString  output  1  one-cycle strobe: datapath latches the new string.
REQ-011 CompareString  output  1  one-cycle strobe: comparer samples the string.
REQ-012 LoadChar  output  1  one-cycle strobe: datapath loads the head character into DataChar.
REQ-013 ShiftString  output  1  one-cycle strobe: datapath advances the string by one character.
REQ-014 Column  output  3  current column index 0..COLS_PER_CHAR (COLS_PER_CHAR = gap).
REQ-015 LedEnable  output  1  1 while a lit column (Column < COLS_PER_CHAR) is displayed.
REQ-016 Busy  output  1  1 in every state except IDLE.
REQ-017 EmptyString  output  1  sticky; set when NullString seen, cleared on next LoadString.
REQ-018 Overrun  output  1  one-cycle pulse when IndexSync arrives before the string finished.

Function
REQ-019 States SHALL be IDLE, WAIT_SYNC, LOAD, CHECK, CHK_WAIT, FETCH, FETCH_WAIT, COLUMN, NEXT.
REQ-020 IDLE: Enable=1 -> WAIT_SYNC; otherwise remain.
REQ-021 WAIT_SYNC: IndexSync=1 -> LOAD; Enable=0 -> IDLE.
REQ-022 LOAD: assert LoadString one cycle, clear EmptyString, char count := 0 -> CHECK.
REQ-023 CHECK: assert CompareString one cycle -> CHK_WAIT.
REQ-024 CHK_WAIT (one cycle, CompareString low): NullString=1 -> set EmptyString, -> WAIT_SYNC; else -> FETCH.
REQ-025 FETCH: assert LoadChar one cycle -> FETCH_WAIT.
REQ-026 FETCH_WAIT (one cycle): NullDataChar=1 -> WAIT_SYNC (end of string); else Column := 0, column timer := 0 -> COLUMN.
REQ-027 COLUMN: timer counts 0..COL_CYCLES-1; at COL_CYCLES-1 with Column < COLS_PER_CHAR, Column increments and timer clears; at COL_CYCLES-1 with Column = COLS_PER_CHAR -> NEXT.
REQ-028 NEXT: assert ShiftString one cycle, char count increments; count = MAX_CHARS or Enable=0 -> WAIT_SYNC or IDLE respectively; else -> FETCH.
REQ-029 LedEnable SHALL be 1 only in COLUMN with Column < COLS_PER_CHAR; 0 in all other states.
REQ-030 Strobe outputs SHALL be registered, mutually exclusive, and never high two consecutive cycles.
REQ-031 IndexSync in CHECK..NEXT SHALL pulse Overrun the same cycle and force LOAD next cycle; IndexSync in WAIT_SYNC is not an overrun.
REQ-032 IndexSync coinciding with Enable=0 in WAIT_SYNC: IDLE wins.
REQ-033 Timer SHALL be wide enough for COL_CYCLES-1 without wrap; char count wide enough for MAX_CHARS.
REQ-034 Latency IndexSync -> first LedEnable SHALL be exactly 6 cycles (LOAD, CHECK, CHK_WAIT, FETCH, FETCH_WAIT, then COLUMN).

Reset
REQ-035 Reset=1 SHALL force IDLE, all strobes 0, Column=0, LedEnable=0, Busy=0, EmptyString=0, Overrun=0, timer and char count 0, regardless of state, taking effect at the next rising edge.
REQ-036 Reset SHALL dominate Enable and IndexSync in the same cycle.

Verification
REQ-037 Enable=1, IndexSync pulse, NullString=0, NullDataChar=0, COL_CYCLES=4 -> LoadString, CompareString, LoadChar in order; LedEnable high 6 cycles later; Column 0..5 each 4 cycles; ShiftString once; 7 characters then WAIT_SYNC.
REQ-038 NullString=1 after CompareString -> EmptyString=1, no LoadChar, returns to WAIT_SYNC; next sync LoadString clears EmptyString.
REQ-039 NullDataChar=1 on third FETCH_WAIT -> exactly 2 ShiftString pulses, state WAIT_SYNC, LedEnable 0.
REQ-040 IndexSync during COLUMN of char 3 -> Overrun pulse same cycle, LoadString next cycle, Column reset to 0.
REQ-041 Enable dropped mid-character -> character completes including gap, ShiftString, then IDLE with Busy=0.
REQ-042 Reset asserted in COLUMN with Column=3 -> next cycle all outputs at reset values, IDLE.
